mole_hit_detector: RTL and testbench
====================================

MOLE_HIT_DETECTOR -- requirements
Module: mole_hit_detector

Interface
REQ-001 Parameter N_MOLES, default 18: number of mole LEDs and slide switches.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: clk cycles between debounce sample ticks (1 ms at 50 MHz).
REQ-003 Parameter SCORE_W, default 8: width of the score counter.
REQ-004 The port list SHALL be, one per line:
- clk  input  1  system clock; the single clock for all logic.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- SW  input  N_MOLES  raw, asynchronous slide switches.
- leds  input  N_MOLES  currently lit mole pattern from the mole generator.
- active  input  1  whack window open, driven by the game FSM.
- hit  output  1  one-cycle pulse: a lit mole was whacked.
- miss  output  1  one-cycle pulse: wrong switch, or the window closed unanswered.
- hit_index  output  5  index of the scoring switch, valid while done=1 after a hit.
- score  output  SCORE_W  running hit count.
- done  output  1  level; the window has been resolved.

Function
REQ-005 Each SW bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-006 A shared prescaler SHALL assert a one-cycle tick every DEBOUNCE_CYCLES clks.
REQ-007 A bit's debounced state SHALL update only when its synchronized value at two consecutive ticks agrees and differs from the current debounced state.
REQ-008 Such an update SHALL raise that bit in a one-cycle toggle vector; both up and down moves count as a whack.
REQ-009 The FSM SHALL have states IDLE, WINDOW, HIT, MISS and DONE.
- IDLE: active=1 -> WINDOW.
- WINDOW: any toggle bit with the matching leds bit =1 -> HIT.
- WINDOW: otherwise, any toggle -> MISS.
- WINDOW: active=0 with no toggle -> MISS.
- HIT and MISS each last exactly one cycle, then go to DONE.
- DONE: active=0 -> IDLE.
REQ-010 Outputs SHALL be Moore: hit=1 only in HIT; miss=1 only in MISS; done=1 only in DONE.
REQ-011 If several toggled bits coincide with lit leds, hit_index SHALL capture the lowest such index.
REQ-012 hit_index SHALL hold its value until the next HIT.
REQ-013 If a toggle and active falling occur in the same WINDOW cycle, the toggle SHALL decide the outcome.
REQ-014 Toggles in IDLE, HIT, MISS or DONE SHALL be ignored; debounced state still tracks the switches.
REQ-015 On entry to HIT, score SHALL increment by 1 and saturate at 2^SCORE_W-1.
REQ-016 hit or miss SHALL assert within 2*DEBOUNCE_CYCLES+5 clks of a stable raw switch change made during WINDOW.

Reset
REQ-017 When reset=0, at the clock edge: state=IDLE; hit=miss=done=0; hit_index=0; score=0; prescaler=0; synchronizers=0.
REQ-018 The first two ticks after reset release SHALL load debounced state from the switches without raising toggles, so switches already up produce no spurious whack.
REQ-019 Reset asserted in any state, including mid-window, SHALL abort the window with no hit or miss pulse.

Configuration
REQ-020 With macro MISS_PENALTY_EN defined, entry to MISS SHALL decrement score by 1, floored at 0.
REQ-021 Without MISS_PENALTY_EN, miss SHALL NOT change score.

Verification (bench uses DEBOUNCE_CYCLES=4, N_MOLES=18)
REQ-022 Reset with SW[3]=1 held, then active=1 with no switch change -> no toggle and no hit/miss while active stays 1; score=0.
REQ-023 leds=18'h00020, active=1, SW[5] 0->1 -> one hit pulse within 13 clks; hit_index=5; score=1; done=1 until active=0.
REQ-024 leds=18'h00020, active=1, SW[2] toggled -> one miss pulse; score unchanged without the macro, or decremented with a 0 floor when MISS_PENALTY_EN is defined.
REQ-025 active=1 for 40 clks with no switch change, then active=0 -> exactly one miss pulse on the following cycle path; done stays 0 afterwards; FSM returns to IDLE.
REQ-026 leds=18'h00110, SW[4] and SW[8] toggled in the same cycle -> one hit; hit_index=4; a further toggle in DONE -> no pulse.
REQ-027 SW[5] bouncing every 2 clks for 20 clks, then settling -> exactly one hit; score at 255 with SCORE_W=8 stays 255 after a hit.

Source files
------------

// File: rtl/mole_hit_detector.sv
// Whack-a-mole hit detector: sync + debounce slide switches, judge whacks against lit LEDs, keep score.
// Latency: a stable switch change is judged within 2*DEBOUNCE_CYCLES+5 clks; outputs are Moore (registered state).
// No backpressure; MISS_PENALTY_EN makes each miss subtract one point (floored at 0).
module mole_hit_detector #(
    parameter int N_MOLES         = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_MOLES-1:0] SW,
    input  logic [N_MOLES-1:0] leds,
    input  logic               active,
    output logic               hit,
    output logic               miss,
    output logic [4:0]         hit_index,
    output logic [SCORE_W-1:0] score,
    output logic               done
);
    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WINDOW, HIT, MISS, DONE} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      pre_cnt;
    logic               tick;
    logic [N_MOLES-1:0] sync1, sync2;
    logic [N_MOLES-1:0] sample_q, deb_q;
    logic [1:0]         init_cnt;
    logic               init_done;
    logic [N_MOLES-1:0] toggle;
    logic [N_MOLES-1:0] lit_toggle;
    logic [4:0]         idx_nxt;

    assign tick      = (pre_cnt == PW'(DEBOUNCE_CYCLES - 1));
    assign init_done = (init_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_cnt <= '0;
            sync1   <= '0;
            sync2   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            sync1   <= SW;
            sync2   <= sync1;
        end
    end

    // A bit moves only when two consecutive tick samples agree and differ from the debounced value.
    assign toggle = (tick && init_done) ? (~(sync2 ^ sample_q) & (sync2 ^ deb_q)) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_q <= '0;
            deb_q    <= '0;
            init_cnt <= '0;
        end else if (tick) begin
            sample_q <= sync2;
            if (!init_done) begin
                deb_q    <= sync2;
                init_cnt <= init_cnt + 2'd1;
            end else begin
                deb_q <= deb_q ^ toggle;
            end
        end
    end

    assign lit_toggle = toggle & leds;

    always_comb begin
        idx_nxt = '0;
        for (int i = N_MOLES - 1; i >= 0; i--) begin
            if (lit_toggle[i]) idx_nxt = 5'(i);
        end
    end

    // A toggle outranks active falling in the same WINDOW cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (active) state_nxt = WINDOW;
            WINDOW: begin
                if (|lit_toggle)  state_nxt = HIT;
                else if (|toggle) state_nxt = MISS;
                else if (!active) state_nxt = MISS;
            end
            HIT:     state_nxt = DONE;
            MISS:    state_nxt = DONE;
            DONE:    if (!active) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hit_index <= '0;
            score     <= '0;
        end else begin
            state <= state_nxt;
            if (state == WINDOW && state_nxt == HIT) begin
                hit_index <= idx_nxt;
                if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
            end
`ifdef MISS_PENALTY_EN
            if (state == WINDOW && state_nxt == MISS && score != '0)
                score <= score - SCORE_W'(1);
`endif
        end
    end

    assign hit  = (state == HIT);
    assign miss = (state == MISS);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector with DEBOUNCE_CYCLES=4, N_MOLES=18, SCORE_W=8.
module tb_mole_hit_detector;
    localparam int N = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  SW;
    logic [N-1:0]  leds;
    logic          active;
    logic          hit, miss, done;
    logic [4:0]    hit_index;
    logic [7:0]    score;

    int errors = 0;
    int checks = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int exp_score = 0;
    int cyc, h0, m0;

    mole_hit_detector #(.N_MOLES(N), .DEBOUNCE_CYCLES(4), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .SW(SW), .leds(leds), .active(active),
        .hit(hit), .miss(miss), .hit_index(hit_index), .score(score), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hit)  hit_cnt++;
        if (miss) miss_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input bit want_hit, input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_hit ? hit : miss) begin
                c = i + 1;
                break;
            end
        end
    endtask

    task automatic model_hit();
        if (exp_score < 255) exp_score++;
    endtask

    task automatic model_miss();
`ifdef MISS_PENALTY_EN
        if (exp_score > 0) exp_score--;
`endif
    endtask

    task automatic play_hit();
        int c;
        leds   = 18'h00020;
        active = 1'b1;
        @(negedge clk);
        SW[5] = ~SW[5];
        wait_pulse(1'b1, 13, c);
        check("loop_hit_seen", c > 0, 1);
        model_hit();
        @(negedge clk);
        active = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        SW     = '0;
        SW[3]  = 1'b1;
        leds   = '0;
        active = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        check("rst_done", done, 0);
        check("rst_hit_index", hit_index, 0);
        check("rst_score", score, 0);
        reset = 1'b1;
        repeat (12) @(negedge clk);

        // Switch already up at reset: window stays open with no whack, then times out.
        h0 = hit_cnt; m0 = miss_cnt;
        active = 1'b1;
        repeat (40) @(negedge clk);
        check("preset_sw_no_pulse", (hit_cnt - h0) + (miss_cnt - m0), 0);
        check("preset_sw_score", score, 0);
        check("open_window_done", done, 0);
        active = 1'b0;
        wait_pulse(1'b0, 4, cyc);
        check("timeout_miss_cycle", cyc, 1);
        model_miss();
        @(negedge clk);
        check("timeout_done_pulse", done, 1);
        @(negedge clk);
        check("timeout_back_idle", done, 0);
        repeat (3) @(negedge clk);
        check("timeout_one_miss", miss_cnt - m0, 1);
        check("timeout_no_hit", hit_cnt - h0, 0);
        check("timeout_score", score, exp_score);
        check("timeout_done_stays_0", done, 0);

        // Lit mole 5 whacked.
        h0 = hit_cnt; m0 = miss_cnt;
        leds = 18'h00020;
        active = 1'b1;
        @(negedge clk);
        SW[5] = 1'b1;
        wait_pulse(1'b1, 13, cyc);
        check("hit5_within_13", cyc > 0, 1);
        model_hit();
        @(negedge clk);
        check("hit5_one_cycle", hit, 0);
        check("hit5_done", done, 1);
        check("hit5_index", hit_index, 5);
        check("hit5_score", score, exp_score);
        repeat (5) @(negedge clk);
        check("hit5_done_held", done, 1);
        active = 1'b0;
        @(negedge clk);
        check("hit5_done_cleared", done, 0);
        repeat (2) @(negedge clk);
        check("hit5_count", hit_cnt - h0, 1);
        check("hit5_no_miss", miss_cnt - m0, 0);

        // Wrong switch.
        h0 = hit_cnt; m0 = miss_cnt;
        active = 1'b1;
        @(negedge clk);
        SW[2] = 1'b1;
        wait_pulse(1'b0, 13, cyc);
        check("wrong_sw_miss", cyc > 0, 1);
        model_miss();
        @(negedge clk);
        check("wrong_sw_score", score, exp_score);
        check("wrong_sw_index_held", hit_index, 5);
        active = 1'b0;
        repeat (3) @(negedge clk);
        check("wrong_sw_one_miss", miss_cnt - m0, 1);
        check("wrong_sw_no_hit", hit_cnt - h0, 0);

        // Two lit moles whacked together, then a whack while resolved.
        h0 = hit_cnt; m0 = miss_cnt;
        leds = 18'h00110;
        active = 1'b1;
        @(negedge clk);
        SW[4] = 1'b1;
        SW[8] = 1'b1;
        wait_pulse(1'b1, 13, cyc);
        check("dual_hit_seen", cyc > 0, 1);
        model_hit();
        @(negedge clk);
        check("dual_hit_index", hit_index, 4);
        check("dual_hit_score", score, exp_score);
        SW[7] = 1'b1;
        repeat (15) @(negedge clk);
        check("done_toggle_ignored_hits", hit_cnt - h0, 1);
        check("done_toggle_ignored_miss", miss_cnt - m0, 0);
        check("done_toggle_done_held", done, 1);
        active = 1'b0;
        repeat (3) @(negedge clk);

        // Bouncing switch settles to a single whack.
        h0 = hit_cnt; m0 = miss_cnt;
        leds = 18'h00020;
        active = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            SW[5] = ~SW[5];
            repeat (2) @(negedge clk);
        end
        SW[5] = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_one_hit", hit_cnt - h0, 1);
        check("bounce_no_miss", miss_cnt - m0, 0);
        model_hit();
        check("bounce_score", score, exp_score);
        active = 1'b0;
        repeat (3) @(negedge clk);

        // Drive score to saturation, then one more hit.
        while (exp_score < 255) play_hit();
        check("sat_reached", score, 255);
        play_hit();
        check("sat_held", score, 255);
        check("sat_index", hit_index, 5);

        // Reset mid-window aborts without a pulse.
        active = 1'b1;
        @(negedge clk);
        SW[5] = ~SW[5];
        @(negedge clk);
        h0 = hit_cnt; m0 = miss_cnt;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_score", score, 0);
        check("midrst_index", hit_index, 0);
        check("midrst_done", done, 0);
        reset  = 1'b1;
        active = 1'b0;
        repeat (12) @(negedge clk);
        active = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_pulse", (hit_cnt - h0) + (miss_cnt - m0), 0);
        active = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
